// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into programmable-length output levels.
// Events arriving while a pulse is active are queued and replayed after a low gap, or retrigger the pulse.
module pulse_stretcher #(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int PEND_W     = 4,
    parameter int RETRIGGER  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  len,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [1:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  gcnt, gcnt_nx;
    logic [CNT_W-1:0]  leff_m1;
    logic [PEND_W-1:0] pend_nx;
    logic              ovf_nx;
    logic              enq, deq;

    // A zero length still produces a one-cycle pulse, so the load value is Leff-1 with len==0 mapped to 0.
    assign leff_m1 = (len == '0) ? '0 : len - CNT_W'(1);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gcnt_nx  = gcnt;
        enq      = 1'b0;
        deq      = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nx = HIGH;
                    cnt_nx   = leff_m1;
                end
            end
            HIGH: begin
                if (pulse_in && (RETRIGGER != 0)) begin
                    cnt_nx = leff_m1;
                end else begin
                    enq = pulse_in;
                    if (cnt == '0) begin
                        state_nx = GAP;
                        gcnt_nx  = GAP_LOAD;
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                enq = pulse_in;
                if (gcnt == '0) begin
                    // An event on the last gap cycle is enqueued and consumed on the same edge.
                    if ((pending != '0) || pulse_in) begin
                        state_nx = HIGH;
                        cnt_nx   = leff_m1;
                        deq      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gcnt_nx = gcnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pend_nx = pending;
        ovf_nx  = 1'b0;
        if (enq && !deq) begin
            if (pending == PEND_MAX) ovf_nx  = 1'b1;
            else                     pend_nx = pending + PEND_W'(1);
        end else if (deq && !enq) begin
            pend_nx = pending - PEND_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gcnt      <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            level_out <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            gcnt      <= gcnt_nx;
            pending   <= pend_nx;
            overflow  <= ovf_nx;
            level_out <= (state_nx == HIGH);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three parameter variants against a cycle-count reference model.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] len = 8'd0;

    logic [2:0] lvl, bsy, ovf;
    logic [3:0] pend0, pend2;
    logic [1:0] pend1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(1), .PEND_W(4), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .len(len),
        .level_out(lvl[0]), .busy(bsy[0]), .pending(pend0), .overflow(ovf[0]));
    pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(3), .PEND_W(2), .RETRIGGER(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .len(len),
        .level_out(lvl[1]), .busy(bsy[1]), .pending(pend1), .overflow(ovf[1]));
    pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(2), .PEND_W(4), .RETRIGGER(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .len(len),
        .level_out(lvl[2]), .busy(bsy[2]), .pending(pend2), .overflow(ovf[2]));

    // Model: cycles of high output still owed, gap cycles still owed, and queued events.
    typedef struct {
        int high;
        int gap;
        int pend;
        int ovf;
    } model_t;

    model_t m[3];
    int gap_p[3]  = '{1, 3, 2};
    int pmax_p[3] = '{15, 3, 15};
    int retr_p[3] = '{0, 0, 1};

    function automatic model_t step(model_t cur, logic p, logic [7:0] l, int gap_c, int pmax, int retrig);
        model_t nx = cur;
        int leff = (l == 8'd0) ? 1 : int'(l);
        bit enq = 1'b0;
        bit deq = 1'b0;
        nx.ovf = 0;
        if (cur.high > 0) begin
            if (p && retrig != 0) begin
                nx.high = leff;
            end else begin
                nx.high = cur.high - 1;
                enq = p;
                if (nx.high == 0) nx.gap = gap_c;
            end
        end else if (cur.gap > 0) begin
            enq = p;
            nx.gap = cur.gap - 1;
            if (nx.gap == 0 && (cur.pend > 0 || p)) begin
                deq = 1'b1;
                nx.high = leff;
            end
        end else if (p) begin
            nx.high = leff;
        end
        if (enq && !deq) begin
            if (cur.pend == pmax) nx.ovf = 1;
            else nx.pend = cur.pend + 1;
        end else if (deq && !enq) begin
            nx.pend = cur.pend - 1;
        end
        return nx;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) m[i] <= '{0, 0, 0, 0};
            else        m[i] <= step(m[i], pulse_in, len, gap_p[i], pmax_p[i], retr_p[i]);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pend_of(int j);
        case (j)
            0:       return int'(pend0);
            1:       return int'(pend1);
            default: return int'(pend2);
        endcase
    endfunction

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("dut%0d level", i), int'(lvl[i]), (m[i].high > 0) ? 1 : 0);
                check($sformatf("dut%0d busy", i), int'(bsy[i]), (m[i].high > 0 || m[i].gap > 0) ? 1 : 0);
                check($sformatf("dut%0d pending", i), pend_of(i), m[i].pend);
                check($sformatf("dut%0d overflow", i), int'(ovf[i]), m[i].ovf);
            end
        end
    end

    // Per-run recordings: bit i holds the output observed after edge i of the run.
    logic [63:0] lv_rec[3], bs_rec[3], pv_rec[3], ov_rec[3];
    int hi_cnt[3], rise_cnt[3], mx_pend[3];

    task automatic run_seq(input logic [63:0] pat, input int n, input logic [7:0] l);
        logic [2:0] prev = 3'b000;
        for (int j = 0; j < 3; j++) begin
            lv_rec[j] = '0; bs_rec[j] = '0; pv_rec[j] = '0; ov_rec[j] = '0;
            hi_cnt[j] = 0; rise_cnt[j] = 0; mx_pend[j] = 0;
        end
        for (int i = 0; i < n; i++) begin
            pulse_in = (i < 64) ? pat[i] : 1'b0;
            len = l;
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (i < 64) begin
                    lv_rec[j][i] = lvl[j];
                    bs_rec[j][i] = bsy[j];
                    pv_rec[j][i] = (pend_of(j) != 0);
                    ov_rec[j][i] = ovf[j];
                end
                if (lvl[j]) hi_cnt[j]++;
                if (lvl[j] && !prev[j]) rise_cnt[j]++;
                if (pend_of(j) > mx_pend[j]) mx_pend[j] = pend_of(j);
            end
            prev = lvl;
        end
        pulse_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bsy != 3'b000 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle timeout", int'(bsy != 3'b000), 0);
    endtask

    int dens = 25;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset level", int'(lvl[0]), 0);
        check("reset busy", int'(bsy[0]), 0);
        check("reset pending", int'(pend0), 0);
        check("reset overflow", int'(ovf[0]), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single pulse, len=3.
        run_seq(64'h1, 6, 8'd3);
        check("t1 level", int'(lv_rec[0]), 'h07);
        check("t1 busy", int'(bs_rec[0]), 'h0F);
        check("t1 pending", int'(pv_rec[0]), 0);
        check("t1 busy gap3", int'(bs_rec[1]), 'h3F);
        wait_idle(50);

        // Length boundaries.
        run_seq(64'h1, 4, 8'd0);
        check("t2 len0 level", int'(lv_rec[0]), 'h1);
        wait_idle(50);
        run_seq(64'h1, 300, 8'd255);
        check("t2 len255 high", hi_cnt[0], 255);
        check("t2 len255 rises", rise_cnt[0], 1);
        check("t2 len255 retrig high", hi_cnt[2], 255);
        wait_idle(50);

        // Back-to-back pulses queue one event.
        run_seq(64'h3, 12, 8'd4);
        check("t3 level", int'(lv_rec[0]), 'h1EF);
        check("t3 pending", int'(pv_rec[0]), 'h1E);
        wait_idle(50);

        // Pulse on the last gap cycle with nothing queued.
        run_seq(64'h9, 8, 8'd2);
        check("t3b level", int'(lv_rec[0]), 'h1B);
        check("t3b busy", int'(bs_rec[0]), 'h3F);
        check("t3b pending", int'(pv_rec[0]), 0);
        wait_idle(50);

        // Burst into a 2-bit queue.
        run_seq(64'h7F, 64, 8'd8);
        check("t4 overflow", int'(ov_rec[1]), 'h70);
        check("t4 max pending", mx_pend[1], 3);
        check("t4 pulses", rise_cnt[1], 4);
        check("t4 pulses wide queue", rise_cnt[0], 7);
        check("t4 max pending wide", mx_pend[0], 6);
        check("t4 retrig high", hi_cnt[2], 14);
        check("t4 retrig rises", rise_cnt[2], 1);
        wait_idle(200);

        // Retrigger on the second high cycle.
        run_seq(64'h5, 10, 8'd4);
        check("t5 retrig level", int'(lv_rec[2]), 'h3F);
        check("t5 retrig pending", int'(pv_rec[2]), 0);
        wait_idle(100);

        // Asynchronous reset mid-HIGH with two queued events.
        run_seq(64'h7, 4, 8'd8);
        check("t6 pending before reset", int'(pend0), 2);
        check("t6 model pending", m[0].pend, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async level", int'(lvl), 0);
        check("t6 async busy", int'(bsy), 0);
        check("t6 async pending", int'(pend0), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_seq(64'h0, 20, 8'd8);
        check("t6 no resume high", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        check("t6 no resume busy", int'(bs_rec[0] | bs_rec[1] | bs_rec[2]), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 500 == 0) dens = int'($urandom_range(5, 70));
            pulse_in = (int'($urandom_range(0, 99)) < dens);
            len = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        pulse_in = 1'b0;
        wait_idle(6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
